cy_fifo: RTL and testbench



---
 rtl/cy_fifo_pkg.sv | 15 +
 rtl/cy_fifo_ram.sv | 44 ++++
 rtl/cy_fifo.sv | 98 +++++++++
 tb/tb_cy_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cy_fifo_pkg.sv
// ============================================================================
// cy_fifo_pkg : shared default sizing for the radar-to-USB sample FIFO
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cy_fifo_pkg;
  localparam int C_DATA_W = 16;
  localparam int C_DEPTH  = 512;
  // Must satisfy 2**C_CNT_W > C_DEPTH so a completely full FIFO is representable.
  localparam int C_CNT_W  = 10;
  localparam int C_PTR_W  = $clog2(C_DEPTH);
endpackage

`default_nettype wire

// File: rtl/cy_fifo_ram.sv
// ============================================================================
// cy_fifo_ram : DEPTH x DATA_W simple dual-port RAM, registered read port
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cy_fifo_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int PTR_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is never cleared; only the output register sees reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/cy_fifo.sv
// ============================================================================
// cy_fifo : single-clock standard-read FIFO feeding the CY7C68013 EP6_IN writer
// Revision: 1.0
// ============================================================================
`default_nettype none

module cy_fifo
  import cy_fifo_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int DEPTH  = C_DEPTH,
  parameter int CNT_W  = C_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  rd_data_count,
  output logic [CNT_W-1:0]  wr_data_count,
  output logic              wr_rst_busy,
  output logic              rd_rst_busy
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_busy_q, rd_busy_q;
  logic             wr_acc, rd_acc;

  always_comb begin
    wr_acc   = wr_en & ~full_q  & ~wr_busy_q;
    rd_acc   = rd_en & ~empty_q & ~rd_busy_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Flags follow the next count so they change on the same edge as it.
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Busy flags are a one-cycle delayed copy of rst, masking the first edge after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      wr_busy_q <= 1'b1;
      rd_busy_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      wr_busy_q <= 1'b0;
      rd_busy_q <= 1'b0;
    end
  end

  cy_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (dout)
  );

  assign full          = full_q;
  assign empty         = empty_q;
  assign rd_data_count = count_q;
  assign wr_data_count = count_q;
  assign wr_rst_busy   = wr_busy_q;
  assign rd_rst_busy   = rd_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cy_fifo.sv
// ============================================================================
// tb_cy_fifo : directed self-checking bench for cy_fifo
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_cy_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] dout;
  logic        full;
  logic        empty;
  logic [9:0]  rd_data_count;
  logic [9:0]  wr_data_count;
  logic        wr_rst_busy;
  logic        rd_rst_busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cy_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .din           (din),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .dout          (dout),
    .full          (full),
    .empty         (empty),
    .rd_data_count (rd_data_count),
    .wr_data_count (wr_data_count),
    .wr_rst_busy   (wr_rst_busy),
    .rd_rst_busy   (rd_rst_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of requests, then sample 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic [15:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    logic [15:0] last;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;

    // Reset and busy release
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_rdcnt", 32'(rd_data_count), 32'd0);
    check_eq("rst_wrcnt", 32'(wr_data_count), 32'd0);
    check_eq("rst_dout", 32'(dout), 32'd0);
    check_eq("rst_wrbusy", 32'(wr_rst_busy), 32'd1);
    check_eq("rst_rdbusy", 32'(rd_rst_busy), 32'd1);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 16'hAAAA);
    check_eq("busy_wr_ignored", 32'(wr_data_count), 32'd0);
    check_eq("busy_empty", 32'(empty), 32'd1);
    check_eq("wrbusy_clear", 32'(wr_rst_busy), 32'd0);
    check_eq("rdbusy_clear", 32'(rd_rst_busy), 32'd0);

    // Basic order
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 16'(i));
    check_eq("basic_cnt4", 32'(rd_data_count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b1, 16'h0);
      check_eq("basic_dout", 32'(dout), 32'(i));
      check_eq("basic_cnt", 32'(rd_data_count), 32'(4 - i));
    end
    check_eq("basic_empty", 32'(empty), 32'd1);

    // Fill, overflow attempt, drain
    for (int i = 0; i < 512; i++) cyc(1'b1, 1'b0, 16'(i));
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_wrcnt", 32'(wr_data_count), 32'd512);
    cyc(1'b1, 1'b0, 16'hBEEF);
    check_eq("ovf_cnt", 32'(wr_data_count), 32'd512);
    check_eq("ovf_full", 32'(full), 32'd1);
    for (int i = 0; i < 512; i++) begin
      cyc(1'b0, 1'b1, 16'h0);
      check_eq("drain_dout", 32'(dout), 32'(i));
    end
    check_eq("drain_empty", 32'(empty), 32'd1);
    check_eq("drain_cnt", 32'(rd_data_count), 32'd0);

    // Underflow: read while empty changes nothing
    cyc(1'b0, 1'b1, 16'h0);
    check_eq("unf_dout", 32'(dout), 32'h01FF);
    check_eq("unf_cnt", 32'(rd_data_count), 32'd0);
    check_eq("unf_empty", 32'(empty), 32'd1);

    // Simultaneous access at count 5
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'(16'h0100 + i));
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b1, 16'(16'h0105 + k));
      check_eq("sim5_dout", 32'(dout), 32'(16'h0100 + k));
      check_eq("sim5_cnt", 32'(rd_data_count), 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 16'h0);
      check_eq("sim5_drain", 32'(dout), 32'(16'h010A + i));
    end
    check_eq("sim5_empty", 32'(empty), 32'd1);

    // Both requests while empty: write only
    cyc(1'b1, 1'b1, 16'h0777);
    check_eq("simE_cnt", 32'(rd_data_count), 32'd1);
    check_eq("simE_dout", 32'(dout), 32'h010E);
    check_eq("simE_empty", 32'(empty), 32'd0);
    cyc(1'b0, 1'b1, 16'h0);
    check_eq("simE_read", 32'(dout), 32'h0777);

    // Both requests while full: read only
    for (int i = 0; i < 512; i++) cyc(1'b1, 1'b0, 16'(16'h2000 + i));
    check_eq("simF_full0", 32'(full), 32'd1);
    cyc(1'b1, 1'b1, 16'hDEAD);
    check_eq("simF_cnt", 32'(rd_data_count), 32'd511);
    check_eq("simF_full", 32'(full), 32'd0);
    check_eq("simF_dout", 32'(dout), 32'h2000);
    for (int i = 1; i < 512; i++) begin
      cyc(1'b0, 1'b1, 16'h0);
      check_eq("simF_drain", 32'(dout), 32'(16'h2000 + i));
    end
    check_eq("simF_empty", 32'(empty), 32'd1);

    // Wrap-around: interleaved write/read pairs
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, 1'b0, 16'(16'h3000 + i));
      check_eq("wrap_cnt1", 32'(rd_data_count), 32'd1);
      check_eq("wrap_flags1", 32'({full, empty}), 32'b00);
      cyc(1'b0, 1'b1, 16'h0);
      check_eq("wrap_dout", 32'(dout), 32'(16'h3000 + i));
      check_eq("wrap_flags0", 32'({full, empty}), 32'b01);
    end
    last = 16'h3000 + 16'd999;
    check_eq("wrap_last", 32'(dout), 32'(last));

    // Mid-operation reset with pending requests
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 16'(16'h4000 + i));
    check_eq("mid_cnt100", 32'(rd_data_count), 32'd100);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 16'h5555);
    rst = 1'b0;
    check_eq("mid_cnt", 32'(rd_data_count), 32'd0);
    check_eq("mid_empty", 32'(empty), 32'd1);
    check_eq("mid_dout", 32'(dout), 32'd0);
    check_eq("mid_busy", 32'({wr_rst_busy, rd_rst_busy}), 32'b11);
    cyc(1'b0, 1'b1, 16'h0);
    check_eq("mid_rd_busy_dout", 32'(dout), 32'd0);
    cyc(1'b0, 1'b1, 16'h0);
    check_eq("mid_rd_empty_dout", 32'(dout), 32'd0);
    check_eq("mid_rd_empty_cnt", 32'(rd_data_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
